// File: rtl/gpmc_pkg.sv
// Shared types and constants for the GPMC initiator.
package gpmc_pkg;

    // Transaction phases of the initiator FSM
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        TURN,
        DATA,
        DONE
    } gpmc_state_t;

    // Read data returned when the target never releases wait
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    // Idle levels of the low-active GPMC strobes and the AD bus
    localparam logic        PIN_IDLE = 1'b1;
    localparam logic [15:0] AD_IDLE  = '0;

    function automatic int unsigned gpmc_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gpmc_phase_counter.sv
// Loadable down-counter with zero flag; times the ADDR, DATA and timeout phases.
module gpmc_phase_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down and stick at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gpmc_initiator.sv
// Wishbone slave issuing one GPMC muxed address/data transaction per cycle.
// Optional macro GPMC_WAIT_EN adds the gpmc_wait input and a data-phase timeout.
module gpmc_initiator
    import gpmc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_CYC   = 2,
    parameter int unsigned DATA_CYC   = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [DATA_WIDTH-1:0] wbs_writedata,
    output logic [DATA_WIDTH-1:0] wbs_readdata,
    input  logic                  wbs_write,
    input  logic                  wbs_strobe,
    input  logic                  wbs_cycle,
    output logic                  wbs_ack,
    output logic [15:0]           gpmc_ad_out,
    output logic                  gpmc_ad_oe,
    input  logic [15:0]           gpmc_ad_in,
    output logic                  gpmc_advn,
    output logic                  gpmc_csn1,
    output logic                  gpmc_wein,
    output logic                  gpmc_oen,
`ifdef GPMC_WAIT_EN
    input  logic                  gpmc_wait,
`endif
    output logic                  gpmc_clk
);

    // One counter width covers every phase length, including the timeout
    localparam int unsigned MAX_CNT = gpmc_max(gpmc_max(ADDR_CYC, DATA_CYC), TIMEOUT);
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    gpmc_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  write_q;
    logic                  req;
    logic                  ph_load;
    logic [CNT_W-1:0]      ph_value;
    logic                  ph_zero;
    logic                  capture;
    logic [DATA_WIDTH-1:0] cap_data;

    assign req = wbs_cycle & wbs_strobe;

    gpmc_phase_counter #(.WIDTH(CNT_W)) u_phase_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (ph_load),
        .load_value(ph_value),
        .en        (1'b1),
        .zero      (ph_zero)
    );

`ifdef GPMC_WAIT_EN
    logic tmo_zero;

    gpmc_phase_counter #(.WIDTH(CNT_W)) u_tmo_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (state_q == TURN),
        .load_value(CNT_W'(TIMEOUT - 1)),
        .en        (state_q == DATA),
        .zero      (tmo_zero)
    );
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Free-running GPMC clock at clk/2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpmc_clk <= 1'b0;
        end else begin
            gpmc_clk <= ~gpmc_clk;
        end
    end

    // Latch the Wishbone request on the accepting edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else if ((state_q == IDLE) && req) begin
            addr_q  <= wbs_address;
            data_q  <= wbs_writedata;
            write_q <= wbs_write;
        end
    end

    // Read data register, updated only on a read capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbs_readdata <= '0;
        end else if (capture) begin
            wbs_readdata <= cap_data;
        end
    end

    // Next-state, phase counter loads and read capture
    always_comb begin
        state_d  = state_q;
        ph_load  = 1'b0;
        ph_value = CNT_W'(ADDR_CYC - 1);
        capture  = 1'b0;
        cap_data = gpmc_ad_in;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ADDR;
                    ph_load = 1'b1;
                end
            end
            ADDR: begin
                if (ph_zero) begin
                    state_d = TURN;
                end
            end
            TURN: begin
                state_d  = DATA;
                ph_load  = 1'b1;
                ph_value = CNT_W'(DATA_CYC - 1);
            end
            DATA: begin
`ifdef GPMC_WAIT_EN
                if (ph_zero && !gpmc_wait) begin
                    state_d = DONE;
                    capture = !write_q;
                end else if (tmo_zero) begin
                    state_d  = DONE;
                    capture  = !write_q;
                    cap_data = TIMEOUT_DATA;
                end
`else
                if (ph_zero) begin
                    state_d = DONE;
                    capture = !write_q;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pins decode from the state register alone, so an async reset idles them at once
    always_comb begin
        gpmc_csn1   = PIN_IDLE;
        gpmc_advn   = PIN_IDLE;
        gpmc_wein   = PIN_IDLE;
        gpmc_oen    = PIN_IDLE;
        gpmc_ad_oe  = 1'b0;
        gpmc_ad_out = AD_IDLE;
        wbs_ack     = 1'b0;
        case (state_q)
            ADDR: begin
                gpmc_csn1   = 1'b0;
                gpmc_advn   = 1'b0;
                gpmc_ad_oe  = 1'b1;
                gpmc_ad_out = 16'(addr_q);
            end
            TURN: begin
                gpmc_csn1  = 1'b0;
                gpmc_ad_oe = write_q;
                if (write_q) begin
                    gpmc_ad_out = 16'(data_q);
                end
            end
            DATA: begin
                gpmc_csn1  = 1'b0;
                gpmc_ad_oe = write_q;
                if (write_q) begin
                    gpmc_wein   = 1'b0;
                    gpmc_ad_out = 16'(data_q);
                end else begin
                    gpmc_oen = 1'b0;
                end
            end
            DONE: begin
                wbs_ack = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
